// File: rtl/cordic_exp_driver.sv
// Request/response wrapper around the 6-bit hyperbolic CORDIC exp core: range-reduces the
// argument to 2^k * e^r, runs the core on r, then rescales the core result by 2^k with saturation.
module cordic_exp_driver #(
    parameter int ARG_W       = 10,
    parameter int LN2         = 22,
    parameter int X_INIT      = 32,
    parameter int INIT_CYCLES = 4,
    parameter int MAX_WAIT    = 64,
    parameter int OUT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ARG_W-1:0] req_arg,
    output logic             core_init,
    output logic [7:0]       core_x,
    output logic [7:0]       core_y,
    output logic [6:0]       core_z,
    input  logic [7:0]       core_exp,
    input  logic             core_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_sat,
    output logic             res_err
);

    localparam int RW    = ARG_W + 1;
    localparam int CNT_W = $clog2(MAX_WAIT + INIT_CYCLES);
    localparam logic signed [RW-1:0] LN2_R  = RW'(LN2);
    localparam logic signed [RW-1:0] HALF_R = RW'(LN2 / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_LAUNCH,
        S_WAIT,
        S_SCALE,
        S_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [RW-1:0]   redArg_q, redArg_d;
    logic signed [5:0]      kExp_q, kExp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             coreExp_q, coreExp_d;
    logic [7:0]             coreX_q, coreX_d;
    logic [7:0]             coreY_q, coreY_d;
    logic [6:0]             coreZ_q, coreZ_d;
    logic [OUT_W-1:0]       resData_q, resData_d;
    logic                   resSat_q, resSat_d;
    logic                   resErr_q, resErr_d;

    logic [6:0]             mag;
    logic [5:0]             negK;
    logic [63:0]            shl;
    logic [OUT_W-1:0]       shr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            redArg_q  <= '0;
            kExp_q    <= '0;
            cnt_q     <= '0;
            coreExp_q <= '0;
            coreX_q   <= '0;
            coreY_q   <= '0;
            coreZ_q   <= '0;
            resData_q <= '0;
            resSat_q  <= 1'b0;
            resErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            redArg_q  <= redArg_d;
            kExp_q    <= kExp_d;
            cnt_q     <= cnt_d;
            coreExp_q <= coreExp_d;
            coreX_q   <= coreX_d;
            coreY_q   <= coreY_d;
            coreZ_q   <= coreZ_d;
            resData_q <= resData_d;
            resSat_q  <= resSat_d;
            resErr_q  <= resErr_d;
        end
    end

    // A negative core result is clamped to zero before rescaling by 2^k.
    always_comb begin
        mag = coreExp_q[7] ? 7'd0 : coreExp_q[6:0];
        negK = 6'(-kExp_q);
        shl = {57'd0, mag} << kExp_q[4:0];
        shr = OUT_W'(mag) >> negK;
    end

    always_comb begin
        state_d   = state_q;
        redArg_d  = redArg_q;
        kExp_d    = kExp_q;
        cnt_d     = cnt_q;
        coreExp_d = coreExp_q;
        coreX_d   = coreX_q;
        coreY_d   = coreY_q;
        coreZ_d   = coreZ_q;
        resData_d = resData_q;
        resSat_d  = resSat_q;
        resErr_d  = resErr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    redArg_d = {req_arg[ARG_W-1], req_arg};
                    kExp_d   = '0;
                    resSat_d = 1'b0;
                    resErr_d = 1'b0;
                    state_d  = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (redArg_q > HALF_R) begin
                    redArg_d = redArg_q - LN2_R;
                    kExp_d   = kExp_q + 6'sd1;
                end else if (redArg_q < -HALF_R) begin
                    redArg_d = redArg_q + LN2_R;
                    kExp_d   = kExp_q - 6'sd1;
                end else begin
                    coreX_d = 8'(X_INIT);
                    coreY_d = 8'd0;
                    coreZ_d = redArg_q[6:0];
                    cnt_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The first WAIT cycle ignores done: the core may still show the previous run's flag.
            S_WAIT: begin
                if ((cnt_q != '0) && core_done) begin
                    coreExp_d = core_exp;
                    state_d   = S_SCALE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    resErr_d  = 1'b1;
                    resData_d = '0;
                    resSat_d  = 1'b0;
                    state_d   = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SCALE: begin
                if (!kExp_q[5]) begin
                    if (|shl[63:OUT_W]) begin
                        resData_d = '1;
                        resSat_d  = 1'b1;
                    end else begin
                        resData_d = shl[OUT_W-1:0];
                        resSat_d  = 1'b0;
                    end
                end else begin
                    resData_d = shr;
                    resSat_d  = 1'b0;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_OUT);
    assign core_init = (state_q == S_LAUNCH);
    assign core_x    = coreX_q;
    assign core_y    = coreY_q;
    assign core_z    = coreZ_q;
    assign res_data  = resData_q;
    assign res_sat   = resSat_q;
    assign res_err   = resErr_q;

endmodule

// File: tb/tb_cordic_exp_driver.sv
// Bench for cordic_exp_driver: directed and random requests against a closed-form reference
// model, with a behavioural CORDIC core that holds a stale done flag into the next run.
module tb_cordic_exp_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_arg = '0;
    logic        core_init;
    logic [7:0]  core_x;
    logic [7:0]  core_y;
    logic [6:0]  core_z;
    logic [7:0]  core_exp = '0;
    logic        core_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_sat;
    logic        res_err;

    int compared = 0;
    int mismatched = 0;

    int modelDelay = 3;
    int modelExp = 32;
    bit modelNever = 1'b0;
    bit armed = 1'b0;
    int waitCnt = 0;
    int initSeen = 0;

    cordic_exp_driver dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_arg(req_arg),
        .core_init(core_init), .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .core_exp(core_exp), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sat(res_sat), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Core model: done appears in the modelDelay-th cycle after init drops and then stays high
    // (stale) through the next launch and that run's first WAIT cycle; exp is noise until then.
    always @(negedge clk) begin
        if (!rst) begin
            armed = 1'b0;
        end else if (core_init) begin
            armed = 1'b1;
            waitCnt = 0;
            initSeen++;
        end else if (armed) begin
            waitCnt++;
            if (waitCnt == 1) begin
                core_exp = 8'($urandom);
            end else if (!modelNever && waitCnt >= modelDelay) begin
                core_done = 1'b1;
                core_exp = 8'(modelExp);
                armed = 1'b0;
            end else begin
                core_done = 1'b0;
                core_exp = 8'($urandom);
            end
            if (waitCnt > 200) armed = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // e^arg = 2^k * e^r with |r| <= 11, so k is the nearest multiple count of ln2 (22) toward zero.
    task automatic computeRef(input int arg, input int expv, output int k, output int r,
                              output int data, output int sat);
        longint v;
        int e;
        if (arg > 11)       k = (arg - 11 + 21) / 22;
        else if (arg < -11) k = -((-arg - 11 + 21) / 22);
        else                k = 0;
        r = arg - 22 * k;
        e = (expv >= 128) ? 0 : expv;
        sat = 0;
        if (k >= 0) begin
            v = longint'(e) * (longint'(1) << k);
            if (v > 65535) begin
                data = 65535;
                sat = 1;
            end else begin
                data = int'(v);
            end
        end else begin
            data = e / (1 << (-k));
        end
    endtask

    task automatic applyStimulus(input int arg, input int expv, input int delay, input bit never,
                                 input int hold);
        int k, r, data, sat, lat, expLat;
        computeRef(arg, expv, k, r, data, sat);
        modelDelay = delay;
        modelExp = expv;
        modelNever = never;
        initSeen = 0;
        checkOutput("reqReadyIdle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_arg = 10'(arg);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        checkOutput("reqReadyBusy", 32'(req_ready), 32'd0);
        while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) begin
            checkOutput("resValidTimeout", 32'(res_valid), 32'd1);
            return;
        end
        expLat = never ? (1 + ((k < 0) ? -k : k) + 1 + 4 + 64)
                       : (1 + ((k < 0) ? -k : k) + 1 + 4 + delay + 1);
        checkOutput($sformatf("latency arg=%0d", arg), 32'(lat), 32'(expLat));
        checkOutput($sformatf("coreZ arg=%0d", arg), 32'(core_z), 32'(r & 8'h7F));
        checkOutput("coreX", 32'(core_x), 32'd32);
        checkOutput("coreY", 32'(core_y), 32'd0);
        checkOutput("initCycles", 32'(initSeen), 32'd4);
        checkOutput($sformatf("resData arg=%0d exp=%0d", arg, expv), 32'(res_data),
                    never ? 32'd0 : 32'(data));
        checkOutput($sformatf("resSat arg=%0d", arg), 32'(res_sat), never ? 32'd0 : 32'(sat));
        checkOutput($sformatf("resErr arg=%0d", arg), 32'(res_err), 32'(never));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(res_valid), 32'd1);
            checkOutput("holdData", 32'(res_data), never ? 32'd0 : 32'(data));
            checkOutput("holdReqReady", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("postHandshakeValid", 32'(res_valid), 32'd0);
        checkOutput("postHandshakeReady", 32'(req_ready), 32'd1);
    endtask

    task automatic resetDuringWait();
        int guard;
        modelDelay = 20;
        modelNever = 1'b0;
        req_valid = 1'b1;
        req_arg = 10'(-70);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!core_init && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (core_init && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachedWait", 32'(guard < 50), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstReqReady", 32'(req_ready), 32'd1);
        checkOutput("rstResValid", 32'(res_valid), 32'd0);
        checkOutput("rstCoreInit", 32'(core_init), 32'd0);
        checkOutput("rstCoreZ", 32'(core_z), 32'd0);
        checkOutput("rstCoreX", 32'(core_x), 32'd0);
        checkOutput("rstResData", 32'(res_data), 32'd0);
        checkOutput("rstResSat", 32'(res_sat), 32'd0);
        checkOutput("rstResErr", 32'(res_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("afterRstReady", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int arg, expv, delay, hold;
        @(negedge clk);
        @(negedge clk);
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetResValid", 32'(res_valid), 32'd0);
        checkOutput("resetCoreInit", 32'(core_init), 32'd0);
        checkOutput("resetResData", 32'(res_data), 32'd0);
        checkOutput("resetCoreX", 32'(core_x), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(0, 32, 3, 1'b0, 0);
        applyStimulus(44, 32, 3, 1'b0, 0);
        applyStimulus(-70, 28, 4, 1'b0, 0);
        applyStimulus(511, 37, 2, 1'b0, 0);
        applyStimulus(-512, 100, 5, 1'b0, 0);
        applyStimulus(11, 200, 3, 1'b0, 0);
        applyStimulus(12, 127, 2, 1'b0, 0);
        applyStimulus(0, 0, 0, 1'b1, 0);
        applyStimulus(0, 32, 3, 1'b0, 0);
        applyStimulus(100, 45, 3, 1'b0, 10);

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 0) arg = int'($urandom_range(0, 1023)) - 512;
            else                           arg = int'($urandom_range(0, 200)) - 100;
            expv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 255))
                                               : int'($urandom_range(0, 127));
            delay = int'($urandom_range(2, 8));
            hold = int'($urandom_range(0, 3));
            applyStimulus(arg, expv, delay, 1'b0, hold);
        end

        applyStimulus(300, 50, 3, 1'b0, 0);
        resetDuringWait();
        applyStimulus(-11, 40, 3, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cordic_exp_driver.md
Name: cordic_exp_driver

Overview:
- Upstream/downstream wrapper around the 6-bit pipelined hyperbolic CORDIC exp core used by the SNN membrane-decay path.
- Accepts a wide signed exponent argument on a valid/ready request interface.
- Range-reduces the argument to e^a = 2^k · e^r with |r| ≤ ln2/2, launches the core with r, waits for core done, then scales the core's exp output by 2^k with saturation.
- Returns the result on a valid/ready response interface.

Parameters:
- ARG_W, 10, width of signed argument; fixed point, 32 = 1.0
- LN2, 22, ln2 in argument units (round(0.693·32))
- X_INIT, 32, initial core x value (1.0); core y init is 0
- INIT_CYCLES, 4, clk cycles core_init is held high (core runs on clk/2 enable)
- MAX_WAIT, 64, clk cycles allowed for core_done before timeout
- OUT_W, 16, unsigned result width; 32 = 1.0

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  argument valid
- req_ready  out  1  driver idle, can accept
- req_arg  in  ARG_W  signed exponent argument
- core_init  out  1  core init/load strobe
- core_x  out  8  core x_i
- core_y  out  8  core y_i
- core_z  out  7  core z_i (reduced argument r)
- core_exp  in  8  core exp_o (signed, 32 = 1.0)
- core_done  in  1  core done
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  OUT_W  e^arg, unsigned, 32 = 1.0
- res_sat  out  1  result saturated high
- res_err  out  1  core timeout

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=1, res_valid=0, res_data=0, res_sat=0, res_err=0, core_init=0, core_x=core_y=core_z=0; k=0, wait counter=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch r=req_arg (sign-extended to ARG_W+1) and k=0, then go to REDUCE.
- REDUCE, one step per cycle:
  - if r>LN2/2 (11): r-=LN2, k+=1;
  - else if r<-(LN2/2): r+=LN2, k-=1;
  - else go to LAUNCH.
  - Duration is |k|+1 cycles.
  - k is signed, 6 bits; |arg| ≤ 511 bounds |k| ≤ 23.
- LAUNCH:
  - core_init=1 for exactly INIT_CYCLES cycles.
  - core_x=X_INIT, core_y=0, core_z=r[6:0].
  - Values are stable during and after init until the next request.
  - Then go to WAIT and clear the wait counter.
- WAIT:
  - core_done is sampled only from the second WAIT cycle onward, because done may still hold its stale value the cycle init drops.
  - When core_done=1: capture core_exp and go to SCALE.
  - When the counter reaches MAX_WAIT: res_err=1, res_data=0, res_sat=0, go to OUT.
- SCALE, one cycle:
  - If core_exp is negative, treat it as 0.
  - If k ≥ 0: v = core_exp << k. If any bit at or above OUT_W is set, res_data=all ones and res_sat=1.
  - If k < 0: res_data = core_exp >> |k| (logical); |k| ≥ 8 yields 0, with no error.
  - Then go to OUT.
- OUT:
  - res_valid=1; res_data/res_sat/res_err are held stable until res_valid&&res_ready.
  - On handshake: res_valid=0, go to IDLE. res_sat/res_err are cleared on the next accepted request.
- req_ready=0 in every state but IDLE; a request arriving in the same cycle as a response handshake is not accepted until the next cycle (IDLE).
- Minimum latency, request accept to res_valid: 1 + (|k|+1) + INIT_CYCLES + 2 + 1 cycles.
- Reset asserted mid-operation aborts immediately to reset values; core_init drops asynchronously with reset.

Test Plan:
- arg=0; core model asserts done 3 cycles after init with core_exp=32 -> core_z=0, k=0, res_data=32, res_sat=0, res_err=0, latency 10 cycles.
- arg=44 -> 2 REDUCE steps, core_z=0, k=2; model returns 32 -> res_data=128.
- arg=-70 -> k=-3, core_z=-4 (7'b1111100); model returns 28 -> res_data=3.
- arg=511 -> k=23, core_z=5; model returns 37 -> res_data=16'hFFFF, res_sat=1.
- Model never asserts done -> after MAX_WAIT=64 WAIT cycles: res_valid=1, res_err=1, res_data=0. Next request with arg=0 completes normally with res_err=0.
- Backpressure and reset:
  - Hold res_ready=0 for 10 cycles -> res_data stable, req_ready=0.
  - Pulse rst=0 during WAIT -> all outputs return to reset values within the same cycle, then req_ready=1.
